// File: rtl/ysyx_20020207_pcu_pkg.sv
// Shared types and constants for the program-counter unit.
//   pcu_state_e  : fetch/commit sequencing states
//   commit_req_t : commit-side redirect payload fed to next-PC selection
//   align4()     : clears the two low PC bits
package pcu_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h3000_0000;
  localparam logic [PC_W-1:0] INST_STEP        = 32'd4;
  localparam logic [PC_W-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_WAIT_INST   = 3'd2,
    ST_WAIT_COMMIT = 3'd3,
    ST_FLUSH       = 3'd4
  } pcu_state_e;

  typedef struct packed {
    logic            trap;
    logic            redirect;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] trap_pc;
  } commit_req_t;

  function automatic logic [PC_W-1:0] align4(input logic [PC_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ysyx_20020207_pcu_next_pc.sv
// Combinational next-PC selection: trap > redirect > PC+4.
// Optional macro PCU_MISALIGN_TRAP_EN: a misaligned selected target is
// replaced by the aligned mtvec and flagged; otherwise targets are aligned.
// Ports:
//   pc           : current PC
//   req          : commit redirect payload
//   mtvec        : trap vector (only consulted with the macro defined)
//   next_pc_c    : selected next PC
//   misalign_c   : selected target was misaligned (0 without the macro)
//   bad_target_c : the offending target (0 without the macro)
module pcu_next_pc
  import pcu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  commit_req_t     req,
  input  logic [PC_W-1:0] mtvec,
  output logic [PC_W-1:0] next_pc_c,
  output logic            misalign_c,
  output logic [PC_W-1:0] bad_target_c
);

  logic            use_target;
  logic [PC_W-1:0] sel_target;

  // Trap outranks a simultaneous branch/jump redirect.
  always_comb begin
    use_target = req.trap | req.redirect;
    sel_target = req.trap ? req.trap_pc : req.target;
  end

`ifdef PCU_MISALIGN_TRAP_EN
  always_comb begin
    misalign_c   = use_target && (sel_target[1:0] != 2'b00);
    bad_target_c = sel_target;
    if (misalign_c) begin
      next_pc_c = align4(mtvec);
    end else if (use_target) begin
      next_pc_c = sel_target;
    end else begin
      next_pc_c = pc + INST_STEP;
    end
  end
`else
  logic unused_mtvec;
  assign unused_mtvec = ^mtvec;

  always_comb begin
    misalign_c   = 1'b0;
    bad_target_c = '0;
    next_pc_c    = use_target ? align4(sel_target) : pc + INST_STEP;
  end
`endif

endmodule

// File: rtl/ysyx_20020207_pcu.sv
// Program-counter unit: holds the architectural PC, issues one fetch
// request per instruction to the IFU and advances the PC on commit.
// Optional macro PCU_MISALIGN_TRAP_EN enables misaligned-target trapping.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   pc_out, pc_ready     : fetch address and one-cycle fetch request to IFU
//   fencei_out           : one-cycle icache invalidate pulse
//   inst_valid           : IFU returned the instruction
//   commit_*             : retire pulse with redirect/trap/fence.i info
//   trap_pc, mtvec       : trap target and trap vector
//   misalign_valid/addr  : misaligned-target event and offending address
module ysyx_20020207_pcu
  import pcu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_ready,
  output logic            fencei_out,
  input  logic            inst_valid,
  input  logic            commit_valid,
  input  logic            commit_redirect,
  input  logic [PC_W-1:0] commit_target,
  input  logic            commit_trap,
  input  logic [PC_W-1:0] trap_pc,
  input  logic            commit_fencei,
  input  logic [PC_W-1:0] mtvec,
  output logic            misalign_valid,
  output logic [PC_W-1:0] misalign_addr
);

  pcu_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_ready_q, pc_ready_d;
  logic            fencei_q, fencei_d;
  logic            mis_valid_q, mis_valid_d;
  logic [PC_W-1:0] mis_addr_q, mis_addr_d;

  commit_req_t     req;
  logic [PC_W-1:0] next_pc_c;
  logic            misalign_c;
  logic [PC_W-1:0] bad_target_c;

  always_comb begin
    req.trap     = commit_trap;
    req.redirect = commit_redirect;
    req.target   = commit_target;
    req.trap_pc  = trap_pc;
  end

  pcu_next_pc u_next_pc (
    .pc           (pc_q),
    .req          (req),
    .mtvec        (mtvec),
    .next_pc_c    (next_pc_c),
    .misalign_c   (misalign_c),
    .bad_target_c (bad_target_c)
  );

  // Pulse outputs are set on the edge that enters the state they belong to,
  // so they are registered yet line up exactly with REQ / FLUSH.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_ready_d  = 1'b0;
    fencei_d    = 1'b0;
    mis_valid_d = 1'b0;
    mis_addr_d  = mis_addr_q;
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_REQ;
        pc_ready_d = 1'b1;
      end
      ST_REQ: begin
        state_d = ST_WAIT_INST;
      end
      ST_WAIT_INST: begin
        if (inst_valid) state_d = ST_WAIT_COMMIT;
      end
      ST_WAIT_COMMIT: begin
        if (commit_valid) begin
          pc_d        = next_pc_c;
          mis_valid_d = misalign_c;
          if (misalign_c) mis_addr_d = bad_target_c;
          if (commit_fencei) begin
            state_d  = ST_FLUSH;
            fencei_d = 1'b1;
          end else begin
            state_d    = ST_REQ;
            pc_ready_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        state_d    = ST_REQ;
        pc_ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      pc_ready_q  <= 1'b0;
      fencei_q    <= 1'b0;
      mis_valid_q <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_ready_q  <= pc_ready_d;
      fencei_q    <= fencei_d;
      mis_valid_q <= mis_valid_d;
      mis_addr_q  <= mis_addr_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_ready       = pc_ready_q;
  assign fencei_out     = fencei_q;
  assign misalign_valid = mis_valid_q;
  assign misalign_addr  = mis_addr_q;

endmodule

// File: tb/tb_ysyx_20020207_pcu.sv
// Scoreboard bench for ysyx_20020207_pcu: the driver pushes expected
// fetch/flush/misalign events with their cycle numbers; a monitor pops
// and compares whenever the DUT pulses an output.
module tb_ysyx_20020207_pcu;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  typedef struct {
    bit          is_flush;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mis_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_out;
  logic        pc_ready;
  logic        fencei_out;
  logic        inst_valid;
  logic        commit_valid;
  logic        commit_redirect;
  logic [31:0] commit_target;
  logic        commit_trap;
  logic [31:0] trap_pc;
  logic        commit_fencei;
  logic [31:0] mtvec;
  logic        misalign_valid;
  logic [31:0] misalign_addr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  mis_t mis_q[$];
  exp_t mon_e;
  mis_t mon_m;

  ysyx_20020207_pcu #(.RESET_PC(RST_PC)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_out          (pc_out),
    .pc_ready        (pc_ready),
    .fencei_out      (fencei_out),
    .inst_valid      (inst_valid),
    .commit_valid    (commit_valid),
    .commit_redirect (commit_redirect),
    .commit_target   (commit_target),
    .commit_trap     (commit_trap),
    .trap_pc         (trap_pc),
    .commit_fencei   (commit_fencei),
    .mtvec           (mtvec),
    .misalign_valid  (misalign_valid),
    .misalign_addr   (misalign_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every REQ/FLUSH pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && (pc_ready || fencei_out)) begin
      if (pc_ready && fencei_out) check("req_flush_overlap", 32'(fencei_out), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: pc_ready=%0b fencei_out=%0b pc_out=0x%08h at cycle %0d",
                 pc_ready, fencei_out, pc_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'(fencei_out), 32'(mon_e.is_flush));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("pc_out", pc_out, mon_e.pc);
`ifndef PCU_MISALIGN_TRAP_EN
        if (pc_ready) begin
          check("misalign_valid_tied", 32'(misalign_valid), 32'd0);
          check("misalign_addr_tied", misalign_addr, 32'd0);
        end
`endif
      end
    end
`ifdef PCU_MISALIGN_TRAP_EN
    if (!reset && misalign_valid) begin
      if (mis_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_misalign: addr=0x%08h at cycle %0d", misalign_addr, cyc);
      end else begin
        mon_m = mis_q.pop_front();
        check("misalign_cycle", 32'(cyc), 32'(mon_m.cyc));
        check("misalign_addr", misalign_addr, mon_m.addr);
      end
    end
`endif
  end

  // Entered at the negedge of a REQ cycle; returns at the next REQ negedge.
  task automatic run_instr(input logic trap, input logic redir,
                           input logic [31:0] tgt, input logic [31:0] tpc,
                           input logic fence, input logic [31:0] exp_pc,
                           input logic mis, input logic [31:0] mis_addr);
    exp_t e;
    mis_t m;
    // Spurious inst_valid/commit_valid during REQ must be ignored.
    commit_trap     = trap;
    commit_redirect = redir;
    commit_target   = tgt;
    trap_pc         = tpc;
    inst_valid      = 1'b1;
    commit_valid    = 1'b1;
    @(negedge clock);
    inst_valid   = 1'b0;
    commit_valid = 1'b0;
    @(negedge clock);
    inst_valid = 1'b1;
    @(negedge clock);
    inst_valid = 1'b0;
    @(negedge clock);
    commit_valid  = 1'b1;
    commit_fencei = fence;
    if (fence) begin
      e.is_flush = 1'b1; e.pc = exp_pc; e.cyc = cyc + 1; exp_q.push_back(e);
      e.is_flush = 1'b0; e.pc = exp_pc; e.cyc = cyc + 2; exp_q.push_back(e);
    end else begin
      e.is_flush = 1'b0; e.pc = exp_pc; e.cyc = cyc + 1; exp_q.push_back(e);
    end
    if (mis) begin
      m.addr = mis_addr; m.cyc = cyc + 1; mis_q.push_back(m);
    end
    @(negedge clock);
    commit_valid    = 1'b0;
    commit_fencei   = 1'b0;
    commit_trap     = 1'b0;
    commit_redirect = 1'b0;
    if (fence) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_out"}, pc_out, RST_PC);
    check({tag, "_pc_ready"}, 32'(pc_ready), 32'd0);
    check({tag, "_fencei_out"}, 32'(fencei_out), 32'd0);
    check({tag, "_misalign_valid"}, 32'(misalign_valid), 32'd0);
    check({tag, "_misalign_addr"}, misalign_addr, 32'd0);
  endtask

  task automatic release_reset();
    exp_t e;
    reset = 1'b0;
    e.is_flush = 1'b0; e.pc = RST_PC; e.cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    inst_valid      = 1'b0;
    commit_valid    = 1'b0;
    commit_redirect = 1'b0;
    commit_target   = '0;
    commit_trap     = 1'b0;
    trap_pc         = '0;
    commit_fencei   = 1'b0;
    mtvec           = 32'h3000_0800;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    release_reset();

    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3000_0004, 1'b0, 32'h0);
    run_instr(1'b1, 1'b1, 32'h3000_0200, 32'h3000_0100, 1'b0, 32'h3000_0100, 1'b0, 32'h0);
    run_instr(1'b0, 1'b1, 32'h3000_0200, 32'h3000_0100, 1'b0, 32'h3000_0200, 1'b0, 32'h0);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3000_0204, 1'b0, 32'h0);
    run_instr(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, 32'h0);
`ifdef PCU_MISALIGN_TRAP_EN
    run_instr(1'b0, 1'b1, 32'h3000_0202, 32'h0, 1'b0, 32'h3000_0800, 1'b1, 32'h3000_0202);
    mtvec = 32'h3000_0803;
    run_instr(1'b1, 1'b0, 32'h0, 32'h0000_1003, 1'b0, 32'h3000_0800, 1'b1, 32'h0000_1003);
`else
    run_instr(1'b0, 1'b1, 32'h3000_0202, 32'h0, 1'b0, 32'h3000_0200, 1'b0, 32'h0);
    mtvec = 32'h3000_0803;
    run_instr(1'b1, 1'b0, 32'h0, 32'h0000_1003, 1'b0, 32'h0000_1000, 1'b0, 32'h0);
`endif
    run_instr(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080, 1'b0, 32'h0000_0040, 1'b0, 32'h0);
    run_instr(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);

    // Asynchronous reset while waiting for the instruction.
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    release_reset();
    run_instr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3000_0004, 1'b0, 32'h0);

    repeat (3) @(negedge clock);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mis_q_drained", 32'(mis_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
